pipeline_skid_stage: RTL and testbench

PIPELINE_SKID_STAGE -- requirements
Module: pipeline_skid_stage

---
 rtl/pipeline_skid_stage.sv | 171 +++++++++++++++++
 tb/tb_pipeline_skid_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_skid_stage.sv
// Two-entry skid buffer pipeline stage (main + skid) with halt lock, flush
// and a saturating back-pressure counter. All outputs come straight from flops.
module pipeline_skid_stage #(
    parameter int                 NB_DATA     = 32,
    parameter int                 NB_CTRL     = 9,
    parameter logic [NB_CTRL-1:0] CTRL_BUBBLE = {NB_CTRL{1'b0}},
    parameter int                 NB_CNT      = 16,
    parameter bit                 NEG_EDGE    = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NB_DATA-1:0] in_data,
    input  logic [NB_CTRL-1:0] in_ctrl,
    input  logic               in_halt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NB_DATA-1:0] out_data,
    output logic [NB_CTRL-1:0] out_ctrl,
    output logic               out_halt,
    output logic               halt_lock,
    output logic [NB_CNT-1:0]  stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [NB_CTRL-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic               main_halt_q, main_halt_d, skid_halt_q, skid_halt_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               halt_lock_q, halt_lock_d;
    logic [NB_CNT-1:0]  stall_q, stall_d;
    logic               accept_s, drain_s;
    logic               active_clk_s;

    // Edge selection is static, so inverting the clock keeps one flop style.
    assign active_clk_s = NEG_EDGE ? ~clock : clock;

    assign accept_s = in_valid & in_ready_q;
    assign drain_s  = out_valid_q & out_ready;

    // Next-state, entry movement, halt lock and stall counter.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        main_halt_d = main_halt_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_halt_d = skid_halt_q;
        halt_lock_d = halt_lock_q;
        stall_d     = stall_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    main_halt_d = in_halt;
                    state_d     = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s && drain_s) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    main_halt_d = in_halt;
                end else if (accept_s) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                    skid_halt_d = in_halt;
                    state_d     = ST_SKID;
                end else if (drain_s) begin
                    // Main ctrl/halt are kept masked whenever the entry is invalid.
                    main_ctrl_d = CTRL_BUBBLE;
                    main_halt_d = 1'b0;
                    state_d     = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_SKID: begin
                if (drain_s) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    main_halt_d = skid_halt_q;
                    state_d     = ST_FULL;
                end else begin
                    state_d = ST_SKID;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (accept_s && in_halt) begin
            halt_lock_d = 1'b1;
        end else begin
            halt_lock_d = halt_lock_q;
        end

        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = CTRL_BUBBLE;
            main_halt_d = 1'b0;
            skid_ctrl_d = CTRL_BUBBLE;
            skid_halt_d = 1'b0;
            halt_lock_d = 1'b0;
        end else begin
            halt_lock_d = halt_lock_d;
        end

        if (out_valid_q && !out_ready && (stall_q != {NB_CNT{1'b1}})) begin
            stall_d = stall_q + {{(NB_CNT-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_SKID) && !halt_lock_d;
    end

    // State and entry registers; reset wins over everything.
    always_ff @(posedge active_clk_s) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= {NB_DATA{1'b0}};
            main_ctrl_q <= CTRL_BUBBLE;
            main_halt_q <= 1'b0;
            skid_data_q <= {NB_DATA{1'b0}};
            skid_ctrl_q <= CTRL_BUBBLE;
            skid_halt_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            halt_lock_q <= 1'b0;
            stall_q     <= {NB_CNT{1'b0}};
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            main_halt_q <= main_halt_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_halt_q <= skid_halt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            halt_lock_q <= halt_lock_d;
            stall_q     <= stall_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = main_data_q;
    assign out_ctrl    = main_ctrl_q;
    assign out_halt    = main_halt_q;
    assign halt_lock   = halt_lock_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Directed bench: a falling-edge default instance and a rising-edge 4-bit-counter
// instance share stimulus; each sees exactly one active edge per step.
module tb_pipeline_skid_stage;

    localparam logic [8:0] BUB0 = 9'h000;
    localparam logic [8:0] BUB1 = 9'h1A5;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_halt, out_ready;
    logic [31:0] in_data;
    logic [8:0]  in_ctrl;

    logic        in_ready0, out_valid0, out_halt0, halt_lock0;
    logic [31:0] out_data0;
    logic [8:0]  out_ctrl0;
    logic [15:0] stall0;
    logic        in_ready1, out_valid1, out_halt1, halt_lock1;
    logic [31:0] out_data1;
    logic [8:0]  out_ctrl1;
    logic [3:0]  stall1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipeline_skid_stage dut0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_halt(in_halt),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_ctrl(out_ctrl0), .out_halt(out_halt0),
        .halt_lock(halt_lock0), .stall_count(stall0)
    );

    pipeline_skid_stage #(
        .NB_DATA(32), .NB_CTRL(9), .CTRL_BUBBLE(BUB1), .NB_CNT(4), .NEG_EDGE(1'b0)
    ) dut1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_halt(in_halt),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_ctrl(out_ctrl1), .out_halt(out_halt1),
        .halt_lock(halt_lock1), .stall_count(stall1)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic h, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = d[8:0] ^ 9'h100;
        in_halt   = h;
        out_ready = rdy;
    endtask

    // Checks the visible head of both instances; data only matters when valid.
    task automatic expect_out(input string tag, input logic v, input logic rdy,
                              input logic [31:0] d, input logic h, input logic lock);
        logic [8:0] c;
        c = d[8:0] ^ 9'h100;
        check_value({tag, ".valid0"}, out_valid0, v);
        check_value({tag, ".valid1"}, out_valid1, v);
        check_value({tag, ".ready0"}, in_ready0, rdy);
        check_value({tag, ".ready1"}, in_ready1, rdy);
        check_value({tag, ".ctrl0"}, out_ctrl0, v ? c : BUB0);
        check_value({tag, ".ctrl1"}, out_ctrl1, v ? c : BUB1);
        check_value({tag, ".halt0"}, out_halt0, v ? h : 1'b0);
        check_value({tag, ".halt1"}, out_halt1, v ? h : 1'b0);
        check_value({tag, ".lock0"}, halt_lock0, lock);
        check_value({tag, ".lock1"}, halt_lock1, lock);
        if (v) begin
            check_value({tag, ".data0"}, out_data0, d);
            check_value({tag, ".data1"}, out_data1, d);
        end
    endtask

    task automatic expect_stall(input string tag, input int s0, input int s1);
        check_value({tag, ".stall0"}, stall0, s0[15:0]);
        check_value({tag, ".stall1"}, stall1, s1[3:0]);
    endtask

    task automatic expect_reset(input string tag);
        expect_out(tag, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        check_value({tag, ".data0"}, out_data0, 32'h0);
        check_value({tag, ".data1"}, out_data1, 32'h0);
        expect_stall(tag, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        expect_reset("reset");

        // Streaming: each beat appears one edge after acceptance.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, i, 1'b0, 1'b1);
            step();
            expect_out($sformatf("stream%0d", i), 1'b1, 1'b1, i, 1'b0, 1'b0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        expect_out("stream_drain", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        expect_stall("stream", 0, 0);

        // Back-pressure: A then B fill main and skid.
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        step();
        expect_out("bp_a", 1'b1, 1'b1, 32'hA, 1'b0, 1'b0);
        expect_stall("bp_a", 0, 0);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step();
        expect_out("bp_b", 1'b1, 1'b0, 32'hA, 1'b0, 1'b0);
        expect_stall("bp_b", 1, 1);
        drive(1'b1, 32'hEE, 1'b0, 1'b0);
        step();
        expect_out("bp_hold", 1'b1, 1'b0, 32'hA, 1'b0, 1'b0);
        expect_stall("bp_hold", 2, 2);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        expect_out("bp_drain_a", 1'b1, 1'b1, 32'hB, 1'b0, 1'b0);
        expect_stall("bp_drain_a", 2, 2);
        step();
        expect_out("bp_drain_b", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

        // Flush in SKID while C is offered: C must never appear.
        drive(1'b1, 32'h21, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        step();
        expect_out("fl_skid", 1'b1, 1'b0, 32'h21, 1'b0, 1'b0);
        expect_stall("fl_skid", 3, 3);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        expect_out("flush", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        expect_stall("flush", 4, 4);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        expect_out("flush_after", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

        // Halt: lock the input until flush.
        drive(1'b1, 32'h48, 1'b1, 1'b0);
        step();
        expect_out("halt_acc", 1'b1, 1'b0, 32'h48, 1'b1, 1'b1);
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        step();
        expect_out("halt_hold", 1'b1, 1'b0, 32'h48, 1'b1, 1'b1);
        expect_stall("halt_hold", 5, 5);
        drive(1'b1, 32'h99, 1'b0, 1'b1);
        step();
        expect_out("halt_drain", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        expect_out("halt_ignore", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        expect_out("halt_flush", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

        // Saturation of the 4-bit counter over 20 stalled edges.
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        expect_out("sat", 1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
        expect_stall("sat", 25, 15);

        // Reset beats flush and a pending accept while FULL.
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        step();
        expect_reset("reset_full");
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
